// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants, colour codes, mode/axis enums and the bar colour helper for the VGA pattern generator.
package vga_pattern_gen_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Colours packed as {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_WHITE  = 8'hFF;
    localparam logic [7:0] COL_DKBLUE = 8'h01;

    typedef enum logic [1:0] {
        MODE_BARS = 2'd0,
        MODE_CHK  = 2'd1,
        MODE_GRAD = 2'd2,
        MODE_BOX  = 2'd3
    } mode_e;

    typedef enum logic {
        AX_INC = 1'b0,
        AX_DEC = 1'b1
    } axis_state_e;

    // Bar index bit 0 drives red, bit 1 green, bit 2 blue: bar 1 is red, bar 7 white.
    function automatic logic [7:0] bar_colour(input logic [2:0] bar);
        return {{3{bar[0]}}, {3{bar[1]}}, {2{bar[2]}}};
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one INC/DEC state machine per axis, advanced once per step pulse.
module vga_box_mover
    import vga_pattern_gen_pkg::*;
#(
    parameter int BOX_SIZE = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       step,
    output logic [9:0] bx,
    output logic [9:0] by
);

    logic [1:0][9:0] pos;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        // Largest legal top-left coordinate so the box stays fully on screen
        localparam logic [9:0] LIMIT = 10'(((gi == 0) ? H_ACTIVE : V_ACTIVE) - BOX_SIZE);

        axis_state_e state_q, state_d;
        logic [9:0]  pos_q, pos_d;

        always_comb begin
            state_d = state_q;
            pos_d   = pos_q;
            if (step) begin
                case (state_q)
                    AX_INC: begin
                        pos_d = pos_q + 10'd1;
                        if (pos_d == LIMIT) state_d = AX_DEC;
                    end
                    AX_DEC: begin
                        pos_d = pos_q - 10'd1;
                        if (pos_d == 10'd0) state_d = AX_INC;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= AX_INC;
                pos_q   <= '0;
            end else begin
                state_q <= state_d;
                pos_q   <= pos_d;
            end
        end

        assign pos[gi] = pos_q;
    end

    assign bx = pos[0];
    assign by = pos[1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern colour generator with sync/blank delay to keep alignment.
// Optional border overlay enabled by defining VGA_PAT_BORDER_EN.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int BAR_W    = 80,
    parameter int CHK_SH   = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       blank,
    input  logic       HS,
    input  logic       VS,
    input  logic [1:0] mode,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [1:0] B,
    output logic       HS_O,
    output logic       VS_O,
    output logic       BLANK_O
);

    logic       hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, blank_s1_q, blank_s1_d;
    logic       hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d, blank_s2_q, blank_s2_d;
    logic       active_s1_q, active_s1_d;
    logic [7:0] bar_col_s1_q, bar_col_s1_d;
    logic [7:0] chk_col_s1_q, chk_col_s1_d;
    logic [7:0] grad_col_s1_q, grad_col_s1_d;
    logic [7:0] box_col_s1_q, box_col_s1_d;
    logic [7:0] rgb_q, rgb_d;
    mode_e      mode_q, mode_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
`ifdef VGA_PAT_BORDER_EN
    logic       border_s1_q, border_s1_d;
`endif

    logic       frame_start;
    logic [9:0] bx, by;
    logic       in_box_x, in_box_y;

    // Stage-2 copy of VS still holds the previous registered value
    assign frame_start = vs_s2_q && !vs_s1_q;

    vga_box_mover #(
        .BOX_SIZE (BOX_SIZE)
    ) u_box_mover (
        .CLK  (CLK),
        .RST  (RST),
        .step (frame_start),
        .bx   (bx),
        .by   (by)
    );

    always_comb begin
        hs_s1_d    = HS;
        vs_s1_d    = VS;
        blank_s1_d = blank;
        hs_s2_d    = hs_s1_q;
        vs_s2_d    = vs_s1_q;
        blank_s2_d = blank_s1_q;

        mode_d      = frame_start ? mode_e'(mode) : mode_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;

        active_s1_d   = !blank && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
        bar_col_s1_d  = bar_colour(3'(x / 10'(BAR_W)));
        chk_col_s1_d  = (x[CHK_SH] ^ y[CHK_SH] ^ frame_cnt_q[5]) ? COL_WHITE : COL_BLACK;
        grad_col_s1_d = {x[9:7], y[8:6], frame_cnt_q[7:6]};

        // 11-bit compares so bx + BOX_SIZE cannot wrap
        in_box_x     = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < ({1'b0, bx} + 11'(BOX_SIZE)));
        in_box_y     = ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < ({1'b0, by} + 11'(BOX_SIZE)));
        box_col_s1_d = (in_box_x && in_box_y) ? COL_WHITE : COL_DKBLUE;

`ifdef VGA_PAT_BORDER_EN
        border_s1_d = (x == 10'd0) || (x == 10'(H_ACTIVE - 1)) ||
                      (y == 10'd0) || (y == 10'(V_ACTIVE - 1));
`endif

        rgb_d = COL_BLACK;
        if (active_s1_q) begin
            case (mode_q)
                MODE_BARS: rgb_d = bar_col_s1_q;
                MODE_CHK:  rgb_d = chk_col_s1_q;
                MODE_GRAD: rgb_d = grad_col_s1_q;
                MODE_BOX:  rgb_d = box_col_s1_q;
            endcase
`ifdef VGA_PAT_BORDER_EN
            if (border_s1_q) rgb_d = COL_WHITE;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            blank_s1_q    <= 1'b1;
            hs_s2_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            blank_s2_q    <= 1'b1;
            active_s1_q   <= 1'b0;
            bar_col_s1_q  <= COL_BLACK;
            chk_col_s1_q  <= COL_BLACK;
            grad_col_s1_q <= COL_BLACK;
            box_col_s1_q  <= COL_BLACK;
            rgb_q         <= COL_BLACK;
            mode_q        <= MODE_BARS;
            frame_cnt_q   <= 8'd0;
`ifdef VGA_PAT_BORDER_EN
            border_s1_q   <= 1'b0;
`endif
        end else begin
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            blank_s1_q    <= blank_s1_d;
            hs_s2_q       <= hs_s2_d;
            vs_s2_q       <= vs_s2_d;
            blank_s2_q    <= blank_s2_d;
            active_s1_q   <= active_s1_d;
            bar_col_s1_q  <= bar_col_s1_d;
            chk_col_s1_q  <= chk_col_s1_d;
            grad_col_s1_q <= grad_col_s1_d;
            box_col_s1_q  <= box_col_s1_d;
            rgb_q         <= rgb_d;
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef VGA_PAT_BORDER_EN
            border_s1_q   <= border_s1_d;
`endif
        end
    end

    assign R       = rgb_q[7:5];
    assign G       = rgb_q[4:2];
    assign B       = rgb_q[1:0];
    assign HS_O    = hs_s2_q;
    assign VS_O    = vs_s2_q;
    assign BLANK_O = blank_s2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: random pixels against a frame-level reference model.
module tb_vga_pattern_gen;

    localparam int BOX  = 32;
    localparam int BARW = 80;
    localparam int CHK  = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] x, y;
    logic       blank, HS, VS;
    logic [1:0] mode;
    logic [2:0] R, G;
    logic [1:0] B;
    logic       HS_O, VS_O, BLANK_O;

    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       bl;
    } exp_t;

    localparam exp_t RESET_EXP = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, bl: 1'b1};

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   nsteps = 0;     // frame starts seen since reset
    int   mode_m = 0;     // mode latched at the last frame start
    bit   vs_prev = 1'b1;

    vga_pattern_gen #(.BOX_SIZE(BOX), .BAR_W(BARW), .CHK_SH(CHK)) dut (
        .CLK(CLK), .RST(RST), .x(x), .y(y), .blank(blank), .HS(HS), .VS(VS),
        .mode(mode), .R(R), .G(G), .B(B), .HS_O(HS_O), .VS_O(VS_O), .BLANK_O(BLANK_O)
    );

    always #5 CLK = ~CLK;

    // Bouncing coordinate after n steps is a triangle wave of period 2*lim
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = n % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic logic [7:0] ref_rgb(input int xi, input int yi, input bit bl);
        int fc, bxm, bym, bar;
        fc  = nsteps % 256;
        bxm = tri_pos(nsteps, 640 - BOX);
        bym = tri_pos(nsteps, 480 - BOX);
        if (bl || xi >= 640 || yi >= 480) return 8'h00;
`ifdef VGA_PAT_BORDER_EN
        if (xi == 0 || xi == 639 || yi == 0 || yi == 479) return 8'hFF;
`endif
        case (mode_m)
            0: begin
                bar = xi / BARW;
                return {((bar % 2) != 0) ? 3'd7 : 3'd0,
                        (((bar / 2) % 2) != 0) ? 3'd7 : 3'd0,
                        (((bar / 4) % 2) != 0) ? 2'd3 : 2'd0};
            end
            1: return ((((xi >> CHK) + (yi >> CHK) + fc / 32) % 2) != 0) ? 8'hFF : 8'h00;
            2: return {3'(xi / 128), 3'((yi / 64) % 8), 2'(fc / 64)};
            default: return (xi >= bxm && xi < bxm + BOX && yi >= bym && yi < bym + BOX) ? 8'hFF : 8'h01;
        endcase
    endfunction

    task automatic check_out(input exp_t e, input string tag);
        checks++;
        assert ({R, G, B} === e.rgb) else begin
            errors++;
            $error("FAIL %s rgb: observed=%h expected=%h", tag, {R, G, B}, e.rgb);
        end
        checks++;
        assert (HS_O === e.hs) else begin
            errors++;
            $error("FAIL %s HS_O: observed=%b expected=%b", tag, HS_O, e.hs);
        end
        checks++;
        assert (VS_O === e.vs) else begin
            errors++;
            $error("FAIL %s VS_O: observed=%b expected=%b", tag, VS_O, e.vs);
        end
        checks++;
        assert (BLANK_O === e.bl) else begin
            errors++;
            $error("FAIL %s BLANK_O: observed=%b expected=%b", tag, BLANK_O, e.bl);
        end
    endtask

    task automatic step(input int xi, input int yi, input bit bl, input bit hs, input bit vs);
        exp_t e;
        x = 10'(xi); y = 10'(yi); blank = bl; HS = hs; VS = vs;
        if (vs_prev && !vs) begin
            nsteps++;
            mode_m = int'(mode);
        end
        vs_prev = vs;
        e.rgb = ref_rgb(xi, yi, bl);
        e.hs = hs; e.vs = vs; e.bl = bl;
        @(posedge CLK); #1;
        expq.push_back(e);
        if (expq.size() >= 2) begin
            e = expq.pop_front();
            check_out(e, "pix");
            $display("pix x=%0d y=%0d blank=%0b mode_m=%0d frame=%0d rgb=%h", xi, yi, bl, mode_m, nsteps, {R, G, B});
        end
    endtask

    task automatic step_pix(input int xi, input int yi);
        step(xi, yi, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic rand_pix(input int n);
        repeat (n) step($urandom_range(0, 700), $urandom_range(0, 520),
                        ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic frame_sync();
        repeat (2) step(10'h3FF, $urandom_range(480, 520), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        repeat (3) step(10'h3FF, $urandom_range(480, 520), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        repeat (2) step(10'h3FF, $urandom_range(480, 520), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic box_probes();
        int bxm, bym;
        bxm = tri_pos(nsteps, 640 - BOX);
        bym = tri_pos(nsteps, 480 - BOX);
        step_pix(bxm, bym);
        step_pix(bxm + BOX - 1, bym + BOX - 1);
        if (bxm > 0) step_pix(bxm - 1, bym);
        if (bxm + BOX < 640) step_pix(bxm + BOX, bym);
        if (bym > 0) step_pix(bxm, bym - 1);
        if (bym + BOX < 480) step_pix(bxm, bym + BOX);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) begin
            x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
            blank = 1'b0; HS = 1'($urandom_range(0, 1)); VS = 1'b0;
            @(posedge CLK); #1;
            check_out(RESET_EXP, "reset");
            $display("reset rgb=%h hs=%b vs=%b blank=%b", {R, G, B}, HS_O, VS_O, BLANK_O);
        end
        RST = 1'b0;
        expq.delete();
        expq.push_back(RESET_EXP);
        nsteps = 0;
        mode_m = 0;
        vs_prev = 1'b1;
    endtask

    initial begin
        mode = 2'd0;
        do_reset();

        // Bars: bar 1 red, right edge white, blanked black
        frame_sync();
        step_pix(85, 10);
        step_pix(639, 10);
        step(85, 10, 1'b1, 1'b1, 1'b1);
        rand_pix(20);

        // HS pattern travels through the two-cycle delay
        step(100, 100, 1'b0, 1'b1, 1'b1);
        step(100, 100, 1'b0, 1'b0, 1'b1);
        step(100, 100, 1'b0, 1'b0, 1'b1);
        step(100, 100, 1'b0, 1'b1, 1'b1);

        // Mid-frame mode change only takes effect at the next VS fall
        mode = 2'd3;
        rand_pix(15);
        frame_sync();
        box_probes();
        rand_pix(10);

        mode = 2'd1;
        frame_sync();
        rand_pix(25);

        mode = 2'd2;
        frame_sync();
        step_pix(0, 200);
        step_pix(639, 479);
        rand_pix(20);

        // Long bounce run, probing the box edges every frame
        mode = 2'd3;
        repeat (700) begin
            frame_sync();
            box_probes();
            rand_pix(1);
        end

        // Late frame counter values exercise checkerboard phase and gradient blue
        mode = 2'd1;
        frame_sync();
        rand_pix(20);
        mode = 2'd2;
        frame_sync();
        rand_pix(20);

        // Reset mid-frame: mode falls back to bars, box back to the origin
        mode = 2'd3;
        rand_pix(3);
        do_reset();
        step_pix(85, 30);
        rand_pix(10);
        frame_sync();
        step_pix(0, 1);
        step_pix(1, 1);
        box_probes();

        step(10'h3FF, 500, 1'b1, 1'b1, 1'b1);
        step(10'h3FF, 500, 1'b1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
